// File: rtl/spi_master_arbiter_pkg.sv
// rtl/spi_master_arbiter_pkg.sv - shared types and widths for the spi_master arbiter
package spi_master_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        RESP,
        GAP
    } state_t;

    // One counter serves both the busy watchdog and the chip-select gap.
    // It must hold BUSY_TIMEOUT-1 and CS_GAP_CYCLES-1.
    localparam int CNT_W = 16;

endpackage

// File: rtl/spi_master_arbiter_rr_arbiter.sv
// rtl/spi_master_arbiter_rr_arbiter.sv - combinational round-robin pick of one requester
//
// Ports:
//   req_i    per-requester request level
//   ptr_i    highest-priority index for this pick (always < N)
//   grant_o  one-hot winner, zero when no request
//   idx_o    binary index of the winner
//   valid_o  at least one request present
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);

    localparam int IW = $clog2(N);

    int          j;
    logic [IW-1:0] jj;
    logic        found;

    // Walk upward from ptr_i, wrapping once; the first set request wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            if (!found && req_i[jj]) begin
                found       = 1'b1;
                grant_o[jj] = 1'b1;
                idx_o       = jj;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin sharing of one spi_master core between requesters
//
// Ports:
//   i_clock, i_reset_n                      clock, async active-low reset
//   i_req / i_req_data / i_req_cpol /
//   i_req_cpha / i_req_divider              per-requester request and transfer mode
//   o_grant                                 one-hot, launch through response
//   o_resp_valid / o_resp_data /
//   o_resp_error                            one-cycle response to the winner
//   o_busy                                  arbiter not idle
//   o_spi_enable / o_spi_cpol / o_spi_cpha /
//   o_spi_divider / o_spi_data              drive the spi_master inputs
//   i_spi_data / i_spi_done / i_spi_busy    spi_master outputs
module spi_master_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ                 = 4,
    parameter int SPI_DATA_WIDTH          = 32,
    parameter int SPI_CLOCK_DIVIDER_WIDTH = 5,
    parameter int CS_GAP_CYCLES           = 8,
    parameter int BUSY_TIMEOUT            = 1023
) (
    input  logic                                              i_clock,
    input  logic                                              i_reset_n,
    input  logic [NUM_REQ-1:0]                                i_req,
    input  logic [NUM_REQ-1:0][SPI_DATA_WIDTH-1:0]            i_req_data,
    input  logic [NUM_REQ-1:0]                                i_req_cpol,
    input  logic [NUM_REQ-1:0]                                i_req_cpha,
    input  logic [NUM_REQ-1:0][SPI_CLOCK_DIVIDER_WIDTH-1:0]   i_req_divider,
    output logic [NUM_REQ-1:0]                                o_grant,
    output logic [NUM_REQ-1:0]                                o_resp_valid,
    output logic [SPI_DATA_WIDTH-1:0]                         o_resp_data,
    output logic                                              o_resp_error,
    output logic                                              o_busy,
    output logic                                              o_spi_enable,
    output logic                                              o_spi_cpol,
    output logic                                              o_spi_cpha,
    output logic [SPI_CLOCK_DIVIDER_WIDTH-1:0]                o_spi_divider,
    output logic [SPI_DATA_WIDTH-1:0]                         o_spi_data,
    input  logic [SPI_DATA_WIDTH-1:0]                         i_spi_data,
    input  logic                                              i_spi_done,
    input  logic                                              i_spi_busy
);

    localparam int IW = $clog2(NUM_REQ);

    state_t                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [IW-1:0]                        ptr_q, ptr_d;
    logic [IW-1:0]                        win_q, win_d;
    logic [NUM_REQ-1:0]                   grant_q, grant_d;
    logic                                 cpol_q, cpol_d;
    logic                                 cpha_q, cpha_d;
    logic [SPI_CLOCK_DIVIDER_WIDTH-1:0]   div_q, div_d;
    logic [SPI_DATA_WIDTH-1:0]            mosi_q, mosi_d;
    logic [SPI_DATA_WIDTH-1:0]            miso_q, miso_d;
    logic                                 err_q, err_d;

    logic [NUM_REQ-1:0]                   pick_grant;
    logic [IW-1:0]                        pick_idx;
    logic                                 pick_valid;
    logic                                 wdog_expired;
    logic                                 gap_done;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // cnt_q is cleared on every state entry, so these compare against
    // "cycles already spent in this state" minus one.
    assign wdog_expired = (cnt_q == CNT_W'(BUSY_TIMEOUT - 1));
    assign gap_done     = (cnt_q == CNT_W'(CS_GAP_CYCLES - 1));

    // State register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            grant_q <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            div_q   <= '0;
            mosi_q  <= '0;
            miso_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            grant_q <= grant_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            div_q   <= div_d;
            mosi_q  <= mosi_d;
            miso_q  <= miso_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        grant_d = grant_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        div_d   = div_q;
        mosi_d  = mosi_q;
        miso_d  = miso_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                // Requester fields are sampled only here and held to RESP.
                if (pick_valid) begin
                    state_d = LAUNCH;
                    grant_d = pick_grant;
                    win_d   = pick_idx;
                    cpol_d  = i_req_cpol[pick_idx];
                    cpha_d  = i_req_cpha[pick_idx];
                    div_d   = i_req_divider[pick_idx];
                    mosi_d  = i_req_data[pick_idx];
                    miso_d  = '0;
                    err_d   = 1'b0;
                end
            end
            LAUNCH: begin
                // A done that races the first busy still counts as the result.
                if (i_spi_done) begin
                    miso_d  = i_spi_data;
                    state_d = RESP;
                end else if (wdog_expired) begin
                    miso_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (i_spi_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_spi_done) begin
                    miso_d  = i_spi_data;
                    state_d = RESP;
                end else if (wdog_expired) begin
                    miso_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                grant_d = '0;
                ptr_d   = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
                state_d = (CS_GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == LAUNCH || state_q == WAIT_DONE || state_q == GAP) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Outputs
    always_comb begin
        o_grant       = grant_q;
        o_resp_valid  = (state_q == RESP) ? grant_q : '0;
        o_resp_data   = (state_q == RESP) ? miso_q : '0;
        o_resp_error  = (state_q == RESP) && err_q;
        o_busy        = (state_q != IDLE);
        o_spi_enable  = (state_q == LAUNCH);
        o_spi_cpol    = cpol_q;
        o_spi_cpha    = cpha_q;
        o_spi_divider = div_q;
        o_spi_data    = mosi_q;
    end

endmodule
